// File: rtl/if_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Holds the FSM state encoding, default widths and the rotated-priority pick.
package if_arb_pkg;

    localparam int unsigned DEF_DW    = 16;
    localparam int unsigned DEF_CW    = 8;
    localparam int unsigned MAXREQ    = 16;
    localparam int unsigned MAXREQ_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        TURN  = 2'd3
    } state_e;

    // One-hot of the first set request at or above ptr, wrapping at nreq.
    function automatic logic [MAXREQ-1:0] rr_onehot(
        input logic [MAXREQ-1:0] req,
        input int unsigned       nreq,
        input int unsigned       ptr
    );
        logic [MAXREQ-1:0] oh;
        int unsigned       idx;
        oh = '0;
        for (int unsigned k = 0; k < MAXREQ; k++) begin
            idx = ptr + k;
            if (idx >= nreq) idx = idx - nreq;
            if ((k < nreq) && (oh == '0) && req[MAXREQ_W'(idx)]) begin
                oh[MAXREQ_W'(idx)] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/if_bus_arbiter_pick.sv
// Combinational round-robin picker: winner one-hot and index from req and rr_ptr.
module if_rr_pick
    import if_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] win_oh_c,
    output logic [PW-1:0]   win_idx_c,
    output logic            any_req_c
);

    logic [MAXREQ-1:0] oh;

    always_comb begin
        oh        = rr_onehot(MAXREQ'(req), NREQ, 32'(rr_ptr));
        win_oh_c  = oh[NREQ-1:0];
        any_req_c = |oh;
        win_idx_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh_c[i]) win_idx_c = PW'(i);
        end
    end

endmodule

// File: rtl/if_bus_arbiter.sv
// Round-robin arbiter sharing one master port of the handshake bus between NREQ requesters.
// Sequence per transfer: grant (IDLE) -> SETUP -> XFER until bus_rdy or timeout -> TURN.
module if_bus_arbiter
    import if_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = DEF_CW
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] req_txd,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [DW-1:0]     rsp_rxd,
    output logic              busy,
    output logic [DW-1:0]     bus_txd,
    output logic              bus_en,
    input  logic              bus_rdy,
    input  logic [DW-1:0]     bus_rxd
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state, state_d;
    logic [NREQ-1:0] gnt_d, done_d, err_d;
    logic [DW-1:0]   rsp_rxd_d, bus_txd_d;
    logic            busy_d, bus_en_d;
    logic [PW-1:0]   rr_ptr, rr_ptr_d, win_q, win_d, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_d;

    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   win_idx;
    logic            any_req;

    if_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .win_oh_c  (win_oh),
        .win_idx_c (win_idx),
        .any_req_c (any_req)
    );

    assign ptr_nxt = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            rsp_rxd <= '0;
            busy    <= 1'b0;
            bus_txd <= '0;
            bus_en  <= 1'b0;
            rr_ptr  <= '0;
            win_q   <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_d;
            gnt     <= gnt_d;
            done    <= done_d;
            err     <= err_d;
            rsp_rxd <= rsp_rxd_d;
            busy    <= busy_d;
            bus_txd <= bus_txd_d;
            bus_en  <= bus_en_d;
            rr_ptr  <= rr_ptr_d;
            win_q   <= win_d;
            cnt     <= cnt_d;
        end
    end

    // Next state and next registered outputs; done/err default low so they pulse once.
    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        done_d    = '0;
        err_d     = '0;
        rsp_rxd_d = rsp_rxd;
        busy_d    = busy;
        bus_txd_d = bus_txd;
        bus_en_d  = bus_en;
        rr_ptr_d  = rr_ptr;
        win_d     = win_q;
        cnt_d     = cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_d     = win_oh;
                    bus_txd_d = req_txd[32'(win_idx) * DW +: DW];
                    busy_d    = 1'b1;
                    win_d     = win_idx;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                bus_en_d = 1'b1;
                cnt_d    = '0;
                state_d  = XFER;
            end
            XFER: begin
                if (bus_rdy) begin
                    rsp_rxd_d = bus_rxd;
                    done_d    = gnt;
                    bus_en_d  = 1'b0;
                    gnt_d     = '0;
                    rr_ptr_d  = ptr_nxt;
                    state_d   = TURN;
                end else if ((TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1))) begin
                    err_d    = gnt;
                    bus_en_d = 1'b0;
                    gnt_d    = '0;
                    rr_ptr_d = ptr_nxt;
                    state_d  = TURN;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            TURN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_if_bus_arbiter.sv
// Directed bench for if_bus_arbiter with TIMEOUT=4: single transfer, round-robin,
// timeout, rdy-on-timeout-edge, dropped request, and asynchronous reset mid-transfer.
module tb_if_bus_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 16;

    logic              ck;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_txd;
    logic [NREQ-1:0]   gnt, done, err;
    logic [DW-1:0]     rsp_rxd, bus_txd, bus_rxd;
    logic              busy, bus_en, bus_rdy;

    int checks = 0;
    int errors = 0;

    if_bus_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(4), .CW(8)) dut (
        .ck      (ck),
        .rst_n   (rst_n),
        .req     (req),
        .req_txd (req_txd),
        .gnt     (gnt),
        .done    (done),
        .err     (err),
        .rsp_rxd (rsp_rxd),
        .busy    (busy),
        .bus_txd (bus_txd),
        .bus_en  (bus_en),
        .bus_rdy (bus_rdy),
        .bus_rxd (bus_rxd)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        req_txd = '0;
        bus_rdy = 1'b0;
        bus_rxd = '0;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bus_en", 32'(bus_en), 0);
        chk("rst_rsp", 32'(rsp_rxd), 0);
        chk("rst_txd", 32'(bus_txd), 0);
        chk("rst_done_err", 32'({done, err}), 0);
        rst_n = 1'b1;

        // Single request, bus_rdy on the third XFER edge
        req = 4'b0001;
        req_txd[15:0] = 16'hA5A5;
        bus_rxd = 16'h1234;
        step();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_en_setup", 32'(bus_en), 0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_txd", 32'(bus_txd), 32'hA5A5);
        req = '0;
        step();
        chk("t1_en", 32'(bus_en), 1);
        chk("t1_txd_x", 32'(bus_txd), 32'hA5A5);
        chk("t1_gnt_x", 32'(gnt), 32'h1);
        step();
        chk("t1_en2", 32'(bus_en), 1);
        chk("t1_nodone", 32'(done), 0);
        step();
        bus_rdy = 1'b1;
        step();
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_rsp", 32'(rsp_rxd), 32'h1234);
        chk("t1_gnt_off", 32'(gnt), 0);
        chk("t1_en_off", 32'(bus_en), 0);
        chk("t1_busy_turn", 32'(busy), 1);
        bus_rdy = 1'b0;
        step();
        chk("t1_done_clr", 32'(done), 0);
        chk("t1_busy_clr", 32'(busy), 0);

        // All four requesting with immediate bus_rdy; reset first so rr_ptr starts at 0
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) req_txd[i*16 +: 16] = 16'(16'h1000 + i);
        bus_rdy = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t2_gnt", 32'(gnt), 32'(1) << (n % 4));
            chk("t2_txd", 32'(bus_txd), 32'h1000 + 32'(n % 4));
            chk("t2_en_setup", 32'(bus_en), 0);
            bus_rxd = 16'(16'h5A00 + n);
            step();
            chk("t2_en", 32'(bus_en), 1);
            step();
            chk("t2_done", 32'(done), 32'(1) << (n % 4));
            chk("t2_rsp", 32'(rsp_rxd), 32'h5A00 + 32'(n));
            chk("t2_gnt_off", 32'(gnt), 0);
            step();
            chk("t2_turn", 32'({done, gnt, 3'(bus_en)}), 0);
        end

        // Timeout: rr_ptr=1, requesters 1 and 2
        bus_rdy = 1'b0;
        req = 4'b0110;
        bus_rxd = 16'hDEAD;
        step();
        chk("t3_gnt", 32'(gnt), 32'h2);
        step();
        chk("t3_en", 32'(bus_en), 1);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t3_wait", 32'({err, 3'(bus_en)}), 1);
        end
        step();
        chk("t3_err", 32'(err), 32'h2);
        chk("t3_nodone", 32'(done), 0);
        chk("t3_rsp_hold", 32'(rsp_rxd), 32'h5A04);
        chk("t3_en_off", 32'(bus_en), 0);
        chk("t3_gnt_off", 32'(gnt), 0);
        step();
        chk("t3_err_clr", 32'(err), 0);

        // Next requester granted; bus_rdy arrives on the timeout edge -> done
        step();
        chk("t4_gnt", 32'(gnt), 32'h4);
        step();
        chk("t4_en", 32'(bus_en), 1);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t4_wait", 32'(err), 0);
        end
        bus_rdy = 1'b1;
        bus_rxd = 16'hC0DE;
        step();
        chk("t4_done", 32'(done), 32'h4);
        chk("t4_noerr", 32'(err), 0);
        chk("t4_rsp", 32'(rsp_rxd), 32'hC0DE);
        bus_rdy = 1'b0;
        req = '0;
        step();

        // req[2] dropped during transfer; bus_rdy in IDLE/SETUP ignored
        req = 4'b0100;
        req_txd[32 +: 16] = 16'h2222;
        bus_rdy = 1'b1;
        step();
        chk("t5_gnt", 32'(gnt), 32'h4);
        chk("t5_txd", 32'(bus_txd), 32'h2222);
        chk("t5_nodone_idle", 32'(done), 0);
        step();
        chk("t5_en", 32'(bus_en), 1);
        chk("t5_nodone_setup", 32'(done), 0);
        req = '0;
        bus_rdy = 1'b0;
        step();
        chk("t5_still", 32'({done, gnt}), 32'h4);
        bus_rdy = 1'b1;
        bus_rxd = 16'hBEEF;
        step();
        chk("t5_done", 32'(done), 32'h4);
        chk("t5_rsp", 32'(rsp_rxd), 32'hBEEF);
        bus_rdy = 1'b0;
        step();

        // Asynchronous reset during XFER
        req = 4'b0001;
        step();
        chk("t6_gnt", 32'(gnt), 32'h1);
        req = '0;
        step();
        chk("t6_en", 32'(bus_en), 1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_en", 32'(bus_en), 0);
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_pulse", 32'({done, err}), 0);
        chk("t6_rst_rsp", 32'(rsp_rxd), 0);
        #1;
        rst_n = 1'b1;
        req = 4'b1000;
        step();
        chk("t6_regnt", 32'(gnt), 32'h8);
        chk("t6_busy", 32'(busy), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
